// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: fixed-priority two-port arbiter with a starvation guard for port 1, sequencing
// one access per cycle into a single-port data memory with 1-cycle registered read data.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN (XLEN = 32 only) rejects illegal byte-enable patterns.
module dmem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p0_valid,
  output logic                p0_ready,
  input  logic                p0_we,
  input  logic [XLEN/8-1:0]   p0_be,
  input  logic [XLEN-1:0]     p0_addr,
  input  logic [XLEN-1:0]     p0_wdata,
  output logic                p0_rsp_valid,
  output logic [XLEN-1:0]     p0_rsp_rdata,
  output logic                p0_rsp_err,
  input  logic                p1_valid,
  output logic                p1_ready,
  input  logic                p1_we,
  input  logic [XLEN/8-1:0]   p1_be,
  input  logic [XLEN-1:0]     p1_addr,
  input  logic [XLEN-1:0]     p1_wdata,
  output logic                p1_rsp_valid,
  output logic [XLEN-1:0]     p1_rsp_rdata,
  output logic                p1_rsp_err,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_byteEnable,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [XLEN-1:0]     mem_wd,
  input  logic [XLEN-1:0]     mem_rd
);
  localparam int unsigned BE_W = XLEN / 8;

  logic [3:0]        starve_cnt;
  logic              starved;
  logic              gnt0, gnt1, gnt_any;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [XLEN-1:0]   sel_addr, sel_wdata;
  logic              issue_err;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wd_q;
  logic              rsp_pend, rsp_port, rsp_we, rsp_bad;
  logic              rsp_live, rd_ok;
  logic              unused_addr_bits;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  // Grants are gated by rst_n so nothing is accepted in a reset cycle.
  always_comb begin
    gnt0 = rst_n & p0_valid & ~(p1_valid & starved);
    gnt1 = rst_n & p1_valid & (~p0_valid | starved);
  end

  assign gnt_any  = gnt0 | gnt1;
  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_comb begin
    if (gnt1) begin
      sel_we    = p1_we;
      sel_be    = p1_be;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else begin
      sel_we    = p0_we;
      sel_be    = p0_be;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!p1_valid || gnt1) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  function automatic logic be_legal(input logic [BE_W-1:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  assign issue_err = gnt_any & ~be_legal(sel_be);

  always_ff @(posedge clk) begin
    if (!rst_n) rsp_bad <= 1'b0;
    else        rsp_bad <= issue_err;
  end
`else
  assign issue_err = 1'b0;
  assign rsp_bad   = 1'b0;
`endif

  // Idle cycles replay the last address/lanes/data; only mem_we matters then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
    end else if (gnt_any) begin
      addr_q <= sel_addr[ADDR_W+1:2];
      be_q   <= sel_be;
      wd_q   <= sel_wdata;
    end
  end

  assign mem_we         = gnt_any & sel_we & ~issue_err;
  assign mem_address    = gnt_any ? sel_addr[ADDR_W+1:2] : addr_q;
  assign mem_byteEnable = gnt_any ? sel_be : be_q;
  assign mem_wd         = gnt_any ? sel_wdata : wd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      rsp_port <= 1'b0;
      rsp_we   <= 1'b0;
    end else begin
      rsp_pend <= gnt_any;
      rsp_port <= gnt1;
      rsp_we   <= sel_we;
    end
  end

  // Responses are also gated by rst_n so a pending response is dropped in the reset cycle.
  assign rsp_live = rst_n & rsp_pend;
  assign rd_ok    = rsp_live & ~rsp_we & ~rsp_bad;

  assign p0_rsp_valid = rsp_live & ~rsp_port;
  assign p1_rsp_valid = rsp_live & rsp_port;
  assign p0_rsp_rdata = (rd_ok & ~rsp_port) ? mem_rd : '0;
  assign p1_rsp_rdata = (rd_ok & rsp_port) ? mem_rd : '0;
  assign p0_rsp_err   = rsp_live & ~rsp_port & rsp_bad;
  assign p1_rsp_err   = rsp_live & rsp_port & rsp_bad;

  assign unused_addr_bits = ^{sel_addr[XLEN-1:ADDR_W+2], sel_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: randomized and directed stimulus against a queue-based reference model;
// expected responses are queued at issue and checked by an independent response monitor.
module tb_dmem_arbiter;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [3:0]  p0_be;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [3:0]  p1_be;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_byteEnable;
  logic [7:0]  mem_address;
  logic [31:0] mem_wd, mem_rd;

  dmem_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_byteEnable(mem_byteEnable), .mem_address(mem_address),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data
  logic [31:0] mem [256];
  logic [31:0] mw;
  always @(posedge clk) begin
    if (mem_we) begin
      mw = mem[mem_address];
      for (int b = 0; b < 4; b++)
        if (mem_byteEnable[b]) mw[8*b +: 8] = mem_wd[8*b +: 8];
      mem[mem_address] <= mw;
    end
    mem_rd <= mem[mem_address];
  end

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [256];
  rsp_t        q[$];
  int          glog[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mstarve = 0;
  bit          run = 0;
  bit          log_en = 0;
  logic [31:0] last0, last1;
  bit          acc0, acc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit be_legal_model(input logic [3:0] be);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: arbitration decision, memory effects and expected response per cycle
  always @(negedge clk) begin
    int          g;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a, wd, data;
    bit          legal;
    if (run) begin
      if (!rst_n) begin
        mstarve = 0;
        check("p0_ready_rst", {31'b0, p0_ready}, 32'd0);
        check("p1_ready_rst", {31'b0, p1_ready}, 32'd0);
        check("mem_we_rst", {31'b0, mem_we}, 32'd0);
      end else begin
        if (p0_valid && p1_valid) g = (mstarve == LIMIT) ? 1 : 0;
        else if (p0_valid)        g = 0;
        else if (p1_valid)        g = 1;
        else                      g = -1;
        if (!p1_valid || g == 1)  mstarve = 0;
        else if (mstarve < LIMIT) mstarve++;
        check("p0_ready", {31'b0, p0_ready}, {31'b0, g == 0});
        check("p1_ready", {31'b0, p1_ready}, {31'b0, g == 1});
        if (log_en) glog.push_back(p1_ready ? 1 : (p0_ready ? 0 : -1));
        if (g >= 0) begin
          we = (g == 1) ? p1_we : p0_we;
          be = (g == 1) ? p1_be : p0_be;
          a  = (g == 1) ? p1_addr : p0_addr;
          wd = (g == 1) ? p1_wdata : p0_wdata;
          legal = be_legal_model(be);
          check("mem_address", {24'b0, mem_address}, {24'b0, a[9:2]});
          check("mem_be", {28'b0, mem_byteEnable}, {28'b0, be});
          check("mem_wd", mem_wd, wd);
          check("mem_we", {31'b0, mem_we}, {31'b0, we && legal});
          data = '0;
          if (legal && we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
          end else if (legal) begin
            data = ref_mem[a[9:2]];
          end
          q.push_back('{cyc, g, data, !legal});
        end else begin
          check("mem_we_idle", {31'b0, mem_we}, 32'd0);
        end
      end
    end
  end

  // Response monitor: the issue from the previous cycle must surface now, on its own port only
  always @(negedge clk) begin
    rsp_t e;
    bit   have;
    if (run) begin
      have = 0;
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        have = 1;
      end
      if (!rst_n) have = 0;
      check("p0_rsp_valid", {31'b0, p0_rsp_valid}, {31'b0, have && e.port == 0});
      check("p1_rsp_valid", {31'b0, p1_rsp_valid}, {31'b0, have && e.port == 1});
      check("p0_rsp_rdata", p0_rsp_rdata, (have && e.port == 0) ? e.data : 32'd0);
      check("p1_rsp_rdata", p1_rsp_rdata, (have && e.port == 1) ? e.data : 32'd0);
      check("p0_rsp_err", {31'b0, p0_rsp_err}, {31'b0, have && e.port == 0 && e.err});
      check("p1_rsp_err", {31'b0, p1_rsp_err}, {31'b0, have && e.port == 1 && e.err});
      if (p0_rsp_valid) last0 = p0_rsp_rdata;
      if (p1_rsp_valid) last1 = p1_rsp_rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  task automatic set0(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    p0_valid = 1'b1; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = wd;
  endtask

  task automatic set1(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    p1_valid = 1'b1; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    idx = 32'($urandom_range(0, 15));
    return ($urandom & 32'hFFFF_FC03) | (idx << 2);
  endfunction

  task automatic check_grants(input string name, input int exp[]);
    check({name, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      check(name, glog[i], exp[i]);
    glog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[8'h30] = 32'h1122_3344; ref_mem[8'h30] = 32'h1122_3344;
    mem[8'h31] = 32'h1122_3344; ref_mem[8'h31] = 32'h1122_3344;
    last0 = '0; last1 = '0;

    // Requests held high during reset must not be granted or written
    rst_n = 1'b0;
    set0(1'b1, 4'hF, 32'h40, 32'h1234_5678);
    set1(1'b1, 4'hF, 32'h44, 32'h8765_4321);
    run = 1;
    repeat (3) step();
    idle();
    rst_n = 1'b1;
    repeat (2) step();

    // Write then read of the same word on consecutive cycles
    set0(1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF); step();
    set0(1'b0, 4'b1111, 32'h0000_0010, 32'h0);          step();
    idle(); repeat (2) step();
    check("raw_readback", last0, 32'hDEAD_BEEF);

    // Single-lane write merges into the preloaded word
    set0(1'b1, 4'b0010, 32'h0000_00C0, 32'h0000_AB00); step();
    set0(1'b0, 4'b1111, 32'h0000_00C0, 32'h0);          step();
    idle(); repeat (2) step();
    check("lane_merge", last0, 32'h1122_AB44);

    // Both ports continuously valid: starvation guard grants p1 every fifth cycle
    set0(1'b0, 4'hF, 32'h50, 32'h0);
    set1(1'b0, 4'hF, 32'h54, 32'h0);
    log_en = 1;
    repeat (10) step();
    log_en = 0;
    idle(); repeat (2) step();
    check_grants("grant_seq", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});

    // Alternating single-port reads must route to the issuing port only
    for (int i = 0; i < 3; i++) begin
      idle(); set1(1'b0, 4'hF, 32'h20, 32'h0); step();
      idle(); set0(1'b0, 4'hF, 32'h24, 32'h0); step();
    end
    idle(); repeat (2) step();

    // Reset in the cycle after a p1 read grant drops its response
    set1(1'b0, 4'hF, 32'h20, 32'h0); step();
    idle(); rst_n = 1'b0; step(); step();
    rst_n = 1'b1; repeat (2) step();
    set0(1'b0, 4'hF, 32'h50, 32'h0);
    set1(1'b0, 4'hF, 32'h54, 32'h0);
    log_en = 1;
    repeat (5) step();
    log_en = 0;
    idle(); repeat (2) step();
    check_grants("grant_after_rst", '{0, 0, 0, 0, 1});

    // Non-contiguous byte enables
    set0(1'b1, 4'b0101, 32'h0000_00C4, 32'hAABB_CCDD); step();
    set0(1'b0, 4'b1111, 32'h0000_00C4, 32'h0);          step();
    idle(); repeat (2) step();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check("be0101_word", last0, 32'h1122_3344);
`else
    check("be0101_word", last0, 32'h11BB_33DD);
`endif

    // Random traffic; requesters hold their fields until accepted
    acc0 = 1; acc1 = 1;
    for (int i = 0; i < 600; i++) begin
      if (!(p0_valid && !acc0)) begin
        p0_valid = ($urandom_range(0, 3) != 0);
        p0_we    = 1'($urandom_range(0, 1));
        p0_be    = 4'($urandom);
        p0_addr  = rand_addr();
        p0_wdata = $urandom;
      end
      if (!(p1_valid && !acc1)) begin
        p1_valid = ($urandom_range(0, 1) != 0);
        p1_we    = 1'($urandom_range(0, 1));
        p1_be    = 4'($urandom);
        p1_addr  = rand_addr();
        p1_wdata = $urandom;
      end
      @(negedge clk);
      acc0 = p0_valid && p0_ready;
      acc1 = p1_valid && p1_ready;
      @(posedge clk);
      #1;
    end
    idle(); repeat (3) step();
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
